// File: rtl/mbist_ctrl.sv
// March C- memory BIST controller: drives a single-port synchronous memory and
// reports pass/fail plus the address and march element of the first mismatch.
module mbist_ctrl #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [ADDR_BITS-1:0] fail_addr,
  output logic [2:0]           fail_elem,
  output logic                 mem_en,
  output logic                 mem_rw,
  output logic [ADDR_BITS-1:0] mem_add,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_drive,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StWrite, StRdIssue, StRdCmp, StDone} state_e;

  localparam logic [ADDR_BITS-1:0] AddrMax = '1;

  state_e               state_q, state_d;
  logic [2:0]           elem_q, elem_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  logic [ADDR_BITS-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]           fail_elem_q, fail_elem_d;

  logic                 down;
  logic                 last_addr;
  logic [ADDR_BITS-1:0] addr_step;
  logic [WORD_SIZE-1:0] exp_word;
  logic [WORD_SIZE-1:0] wr_word;

  // Elements 3..5 walk downwards; element data alternates 0/1 as in March C-.
  assign down      = (elem_q >= 3'd3);
  assign last_addr = down ? (addr_q == '0) : (addr_q == AddrMax);
  assign addr_step = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
  assign exp_word  = (elem_q == 3'd2 || elem_q == 3'd4) ? '1 : '0;
  assign wr_word   = (elem_q == 3'd1 || elem_q == 3'd3) ? '1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      elem_q      <= '0;
      addr_q      <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StWrite;
          elem_d      = '0;
          addr_d      = '0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      StWrite: begin
        if (last_addr) begin
          // Next element starts at the far end when it is a down element.
          elem_d  = elem_q + 3'd1;
          addr_d  = (elem_q >= 3'd2) ? AddrMax : '0;
          state_d = StRdIssue;
        end else begin
          addr_d  = addr_step;
          state_d = (elem_q == 3'd0) ? StWrite : StRdIssue;
        end
      end
      StRdIssue: state_d = StRdCmp;
      StRdCmp: begin
        if (mem_rdata != exp_word) begin
          state_d     = StDone;
          fail_d      = 1'b1;
          fail_addr_d = addr_q;
          fail_elem_d = elem_q;
        end else if (elem_q == 3'd5) begin
          if (last_addr) begin
            state_d = StDone;
            pass_d  = 1'b1;
          end else begin
            addr_d  = addr_step;
            state_d = StRdIssue;
          end
        end else begin
          state_d = StWrite;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_en    = 1'b0;
    mem_rw    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      StWrite: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_rw    = 1'b1;
        mem_wdata = wr_word;
      end
      StRdIssue: begin
        busy   = 1'b1;
        mem_en = 1'b1;
      end
      StRdCmp: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
    mem_add   = busy ? addr_q : '0;
    mem_drive = mem_en & mem_rw;
    pass      = pass_q;
    fail      = fail_q;
    fail_addr = fail_addr_q;
    fail_elem = fail_elem_q;
  end

endmodule

// File: tb/tb_mbist_ctrl.sv
// Directed bench for mbist_ctrl with a synchronous behavioural memory that can
// hold a stuck-at-1 fault on bit 0 of address 0xA.
module tb_mbist_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass, fail;
  logic [3:0] fail_addr;
  logic [2:0] fail_elem;
  logic       mem_en, mem_rw, mem_drive;
  logic [3:0] mem_add;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [16];
  logic       fault_en = 1'b0;

  int checks = 0;
  int failures = 0;

  mbist_ctrl #(.WORD_SIZE(8), .ADDR_BITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .mem_en    (mem_en),
    .mem_rw    (mem_rw),
    .mem_add   (mem_add),
    .mem_wdata (mem_wdata),
    .mem_drive (mem_drive),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Read data appears the cycle after the read is issued.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rw) mem[mem_add] <= mem_wdata;
      else mem_rdata <= mem[mem_add] | ((fault_en && mem_add == 4'hA) ? 8'h01 : 8'h00);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    checks += 11;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", pass); end
    if (fail !== 1'b0) begin failures++; $display("FAIL reset_fail got=%b exp=0", fail); end
    if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", mem_en); end
    if (mem_rw !== 1'b0) begin failures++; $display("FAIL reset_rw got=%b exp=0", mem_rw); end
    if (mem_drive !== 1'b0) begin failures++; $display("FAIL reset_drive got=%b exp=0", mem_drive); end
    if (mem_add !== 4'h0) begin failures++; $display("FAIL reset_add got=%h exp=0", mem_add); end
    if (mem_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    if (fail_addr !== 4'h0) begin failures++; $display("FAIL reset_faddr got=%h exp=0", fail_addr); end
    if (fail_elem !== 3'h0) begin failures++; $display("FAIL reset_felem got=%h exp=0", fail_elem); end
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_prio_busy got=%b exp=0", busy); end
  endtask

  task automatic test_full_pass();
    apply_reset();
    start = 1'b1;
    for (int c = 1; c <= 245; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      checks += 4;
      if (busy !== (c <= 240)) begin
        failures++; $display("FAIL pass_busy c=%0d got=%b exp=%b", c, busy, (c <= 240));
      end
      if (done !== (c >= 241)) begin
        failures++; $display("FAIL pass_done c=%0d got=%b exp=%b", c, done, (c >= 241));
      end
      if (mem_drive !== (mem_en & mem_rw)) begin
        failures++; $display("FAIL pass_drive c=%0d got=%b exp=%b", c, mem_drive, mem_en & mem_rw);
      end
      if (!mem_drive && mem_wdata !== 8'h00) begin
        failures++; $display("FAIL pass_wdata_idle c=%0d got=%h exp=00", c, mem_wdata);
      end
      if (c <= 16) begin
        checks++;
        if ({mem_en, mem_rw, mem_add, mem_wdata} !== {1'b1, 1'b1, 4'(c - 1), 8'h00}) begin
          failures++;
          $display("FAIL m0_write c=%0d got en=%b rw=%b add=%h wd=%h exp en=1 rw=1 add=%h wd=00",
                   c, mem_en, mem_rw, mem_add, mem_wdata, 4'(c - 1));
        end
      end
      if (c == 17 || c == 113 || c == 239) begin
        checks++;
        if ({mem_en, mem_rw, mem_add} !== {1'b1, 1'b0, (c == 113) ? 4'hF : 4'h0}) begin
          failures++;
          $display("FAIL read_issue c=%0d got en=%b rw=%b add=%h", c, mem_en, mem_rw, mem_add);
        end
      end
      if (c == 18 || c == 240) begin
        checks++;
        if (mem_en !== 1'b0) begin failures++; $display("FAIL cmp_en c=%0d got=%b exp=0", c, mem_en); end
      end
      if (c == 19) begin
        checks++;
        if ({mem_en, mem_rw, mem_add, mem_wdata} !== {1'b1, 1'b1, 4'h0, 8'hFF}) begin
          failures++;
          $display("FAIL m1_write got en=%b rw=%b add=%h wd=%h exp 1 1 0 ff",
                   mem_en, mem_rw, mem_add, mem_wdata);
        end
      end
      if (c >= 241) begin
        checks++;
        if ({pass, fail, mem_en} !== 3'b100) begin
          failures++; $display("FAIL pass_result c=%0d got pass=%b fail=%b en=%b exp 1 0 0",
                               c, pass, fail, mem_en);
        end
      end
    end
  endtask

  task automatic test_stuck_fault();
    apply_reset();
    fault_en = 1'b1;
    start    = 1'b1;
    for (int c = 1; c <= 56; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 47) begin
        checks++;
        if ({mem_en, mem_rw, mem_add} !== {1'b1, 1'b0, 4'hA}) begin
          failures++; $display("FAIL fault_issue got en=%b rw=%b add=%h exp 1 0 a",
                               mem_en, mem_rw, mem_add);
        end
      end
      if (c == 48) begin
        checks++;
        if ({mem_en, busy, done} !== 3'b010) begin
          failures++; $display("FAIL fault_cmp got en=%b busy=%b done=%b exp 0 1 0",
                               mem_en, busy, done);
        end
      end
      if (c >= 49) begin
        checks++;
        if ({done, fail, pass, busy, mem_en, fail_addr, fail_elem} !==
            {5'b11000, 4'hA, 3'd1}) begin
          failures++;
          $display("FAIL fault_result c=%0d got done=%b fail=%b pass=%b busy=%b en=%b fa=%h fe=%0d",
                   c, done, fail, pass, busy, mem_en, fail_addr, fail_elem);
        end
      end
    end
    fault_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    start = 1'b1;
    for (int c = 1; c <= 346; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 100) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
      end
      if (c == 101) begin
        rst = 1'b0;
        checks++;
        if ({busy, done, pass, fail, mem_en, mem_rw, mem_drive, mem_add, mem_wdata} !== '0) begin
          failures++;
          $display("FAIL midrst_outputs got busy=%b done=%b pass=%b fail=%b en=%b rw=%b drv=%b add=%h wd=%h",
                   busy, done, pass, fail, mem_en, mem_rw, mem_drive, mem_add, mem_wdata);
        end
      end
      if (c == 102) begin
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%b exp=0", busy); end
      end
      if (c == 103) start = 1'b1;
      if (c == 104) begin
        start = 1'b0;
        checks++;
        if ({busy, mem_en, mem_rw, mem_add} !== {3'b111, 4'h0}) begin
          failures++; $display("FAIL midrst_restart got busy=%b en=%b rw=%b add=%h",
                               busy, mem_en, mem_rw, mem_add);
        end
      end
      if (c == 343) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL midrst_last_busy got=%b exp=1", busy); end
      end
      if (c >= 344) begin
        checks++;
        if ({done, pass, fail, busy} !== 4'b1100) begin
          failures++; $display("FAIL midrst_result c=%0d got done=%b pass=%b fail=%b busy=%b",
                               c, done, pass, fail, busy);
        end
      end
    end
  endtask

  task automatic test_start_held();
    apply_reset();
    start = 1'b1;
    for (int c = 1; c <= 243; c++) begin
      tick();
      if (c == 2) begin
        checks++;
        if ({busy, mem_add} !== {1'b1, 4'h1}) begin
          failures++; $display("FAIL held_norestart got busy=%b add=%h exp 1 1", busy, mem_add);
        end
      end
      if (c == 113) begin
        checks++;
        if ({mem_en, mem_rw, mem_add} !== {1'b1, 1'b0, 4'hF}) begin
          failures++; $display("FAIL held_m3 got en=%b rw=%b add=%h exp 1 0 f", mem_en, mem_rw, mem_add);
        end
      end
      if (c == 240) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL held_busy240 got=%b exp=1", busy); end
      end
      if (c == 241) begin
        checks++;
        if ({done, pass, busy} !== 3'b110) begin
          failures++; $display("FAIL held_done got done=%b pass=%b busy=%b exp 1 1 0", done, pass, busy);
        end
      end
      if (c == 242) begin
        checks++;
        if ({busy, done, pass, mem_en, mem_rw, mem_add} !== {5'b10011, 4'h0}) begin
          failures++;
          $display("FAIL held_restart got busy=%b done=%b pass=%b en=%b rw=%b add=%h",
                   busy, done, pass, mem_en, mem_rw, mem_add);
        end
      end
    end
    start = 1'b0;
    apply_reset();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    #2;
    test_reset();
    test_full_pass();
    test_stuck_fault();
    test_mid_reset();
    test_start_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
